reg_bank_wr: RTL and testbench
==============================

# reg_bank_wr

Write-side register bank and bus slave front end for the project datapath. Holds the 10 data registers (R0–R9), 10 instruction registers (I0–I9) and 3 control registers (OP_START, INT_MASK, INTERRUPT). Decodes bus writes, tracks operation completion into INTERRUPT, and registers the read address. Its register outputs and `rd_sel` feed the 23-to-1 read multiplexer directly downstream.

## Interface
- `clk` in 1: sole clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `S_SEL` in 1: bus access request this cycle.
- `S_WR` in 1: 1 = write, 0 = read; valid when `S_SEL`=1.
- `S_ADDR` in 16: register address, map below.
- `S_DIN` in 64: write data.
- `op_done` in 1: single-cycle completion pulse from the execution core.
- `R0`..`R9` out 64 each: data registers.
- `I0`..`I9` out 64 each: instruction registers.
- `OP_START`, `INT_MASK`, `INTERRUPT` out 64 each: control registers.
- `rd_sel` out 16: registered read address, drives the mux select.
- `rd_valid` out 1: one-cycle pulse, the read data at the mux output is valid.
- `rd_err` out 1: one-cycle pulse coincident with `rd_valid` for an unmapped read.
- `o_irq` out 1: interrupt request.

## Operation
- Address map:
  - 16'h0100–0109 → R0–R9.
  - 16'h0110–0119 → I0–I9.
  - 16'h0120 OP_START, 16'h0121 INT_MASK, 16'h0122 INTERRUPT.
  - All other addresses are unmapped.
- Busy = `OP_START[0]`.
- Write accepted when `S_SEL`=1 and `S_WR`=1. The addressed register loads full 64-bit `S_DIN` at the next edge.
- Unmapped write is ignored silently.
- Writes to R*/I* while busy are ignored. Control registers are always writable.
- On `op_done`=1 with busy=1:
  - `OP_START[0]` clears to 0.
  - `INTERRUPT[0]` sets to 1.
  - Upper OP_START bits are unchanged.
- `op_done` with busy=0 is ignored: no clear, no set.
- Simultaneous bus write to OP_START and `op_done`: the bus write wins, and OP_START takes `S_DIN`.
- Simultaneous bus write to INTERRUPT and a valid `op_done`: `INTERRUPT[63:1]` takes `S_DIN[63:1]`, and `INTERRUPT[0]` is 1 (set wins).
- INTERRUPT is cleared by software writing 0.
- `o_irq` = `INTERRUPT[0]` & `INT_MASK[0]`, combinational from the registered values.
- Read accepted when `S_SEL`=1 and `S_WR`=0:
  - `rd_sel` loads `S_ADDR` at the next edge.
  - `rd_valid` pulses 1 in the following cycle.
  - `rd_err` is 1 in that same cycle if the address is unmapped.
  - `rd_sel` holds its value until the next read.
- Back-to-back reads on consecutive cycles each produce their own `rd_valid` pulse, pipelined.

## Timing
- Reset (`reset_n`=0, asynchronous): every register output, `rd_sel`, `rd_valid` and `rd_err` go to 0 immediately. `o_irq` is therefore 0.
- Write latency: 1 cycle. The register shows the new value in the cycle after the write request.
- Read latency: 1 cycle, request → `rd_valid`. Mux data is valid in the `rd_valid` cycle.
- `op_done` effect is visible 1 cycle after the pulse. `o_irq` rises in the same cycle INTERRUPT[0] becomes 1.
- Reset asserted mid-operation clears busy. An `op_done` arriving after reset is then ignored.
- Write data is never partially applied. There are no byte enables.

## Structure
- Shared package holds:
  - Address constants: `ADDR_R_BASE`=16'h0100, `ADDR_I_BASE`=16'h0110, `ADDR_OP_START`=16'h0120, `ADDR_INT_MASK`=16'h0121, `ADDR_INTERRUPT`=16'h0122.
  - Register count, 10.
  - Data width, 64.
- The same package is used by the downstream mux.
- One sub-module: `_register64_r_en`, a 64-bit register with async active-low reset and load enable. It is instantiated for each of the 20 R/I registers.
- Control registers carry the `op_done` merge logic and are written out in this module.

## Test plan
- Reset, then write 64'h1234 to 16'h0103 → R3=64'h1234 next cycle. All other registers remain 0.
- Write OP_START=1, then write 64'hFF to 16'h0100 → R0 stays 0 (busy). Pulse `op_done` → OP_START=0 and INTERRUPT=1 next cycle.
- INT_MASK=1 with op completion → `o_irq`=1. Write INTERRUPT=0 → `o_irq`=0 next cycle.
- Write INTERRUPT=64'h6 in the same cycle as a valid `op_done` → INTERRUPT=64'h7.
- Read 16'h0121 → `rd_sel`=16'h0121 and `rd_valid`=1 one cycle later. Read 16'h0130 → `rd_valid`=1 and `rd_err`=1.
- Assert `reset_n`=0 mid-operation with OP_START=1 → all outputs 0 immediately. A later `op_done` leaves INTERRUPT=0.

Source files
------------

// File: rtl/reg_bank_wr_pkg.sv
// Shared constants for the register bank write side and the downstream read mux.
// Address map, register count and data width live here so both ends agree.
package reg_bank_wr_pkg;

    localparam int DATA_W    = 64;
    localparam int ADDR_W    = 16;
    localparam int REG_COUNT = 10;

    localparam logic [ADDR_W-1:0] ADDR_R_BASE    = 16'h0100;
    localparam logic [ADDR_W-1:0] ADDR_I_BASE    = 16'h0110;
    localparam logic [ADDR_W-1:0] ADDR_OP_START  = 16'h0120;
    localparam logic [ADDR_W-1:0] ADDR_INT_MASK  = 16'h0121;
    localparam logic [ADDR_W-1:0] ADDR_INTERRUPT = 16'h0122;

    // True when the address selects one of the 23 implemented registers.
    function automatic logic addr_mapped(input logic [ADDR_W-1:0] addr);
        logic r_hit;
        logic i_hit;
        logic c_hit;
        r_hit = (addr >= ADDR_R_BASE) && (addr < ADDR_R_BASE + 16'(REG_COUNT));
        i_hit = (addr >= ADDR_I_BASE) && (addr < ADDR_I_BASE + 16'(REG_COUNT));
        c_hit = (addr >= ADDR_OP_START) && (addr <= ADDR_INTERRUPT);
        return r_hit || i_hit || c_hit;
    endfunction

endpackage

// File: rtl/reg_bank_wr_register64_r_en.sv
// 64-bit storage register with asynchronous active-low clear and load enable.
// Used for every data and instruction register in the bank.
module reg_bank_wr_register64_r_en
    import reg_bank_wr_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] q_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_reg <= '0;
        end else if (en) begin
            q_reg <= d;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/reg_bank_wr.sv
// Bus-slave write side of the register bank: R/I/control register storage,
// op_done completion tracking into INTERRUPT, and the registered read select.
module reg_bank_wr
    import reg_bank_wr_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              S_SEL,
    input  logic              S_WR,
    input  logic [ADDR_W-1:0] S_ADDR,
    input  logic [DATA_W-1:0] S_DIN,
    input  logic              op_done,
    output logic [DATA_W-1:0] R0,
    output logic [DATA_W-1:0] R1,
    output logic [DATA_W-1:0] R2,
    output logic [DATA_W-1:0] R3,
    output logic [DATA_W-1:0] R4,
    output logic [DATA_W-1:0] R5,
    output logic [DATA_W-1:0] R6,
    output logic [DATA_W-1:0] R7,
    output logic [DATA_W-1:0] R8,
    output logic [DATA_W-1:0] R9,
    output logic [DATA_W-1:0] I0,
    output logic [DATA_W-1:0] I1,
    output logic [DATA_W-1:0] I2,
    output logic [DATA_W-1:0] I3,
    output logic [DATA_W-1:0] I4,
    output logic [DATA_W-1:0] I5,
    output logic [DATA_W-1:0] I6,
    output logic [DATA_W-1:0] I7,
    output logic [DATA_W-1:0] I8,
    output logic [DATA_W-1:0] I9,
    output logic [DATA_W-1:0] OP_START,
    output logic [DATA_W-1:0] INT_MASK,
    output logic [DATA_W-1:0] INTERRUPT,
    output logic [ADDR_W-1:0] rd_sel,
    output logic              rd_valid,
    output logic              rd_err,
    output logic              o_irq
);

    logic [DATA_W-1:0] r_q [REG_COUNT];
    logic [DATA_W-1:0] i_q [REG_COUNT];
    logic [REG_COUNT-1:0] r_load;
    logic [REG_COUNT-1:0] i_load;

    logic [DATA_W-1:0] op_start_reg, op_start_next;
    logic [DATA_W-1:0] int_mask_reg, int_mask_next;
    logic [DATA_W-1:0] interrupt_reg, interrupt_next;
    logic [ADDR_W-1:0] rd_sel_reg;
    logic              rd_valid_reg;
    logic              rd_err_reg;

    logic wr_en;
    logic rd_en;
    logic busy;
    logic bank_wr_en;
    logic done_valid;

    assign wr_en      = S_SEL & S_WR;
    assign rd_en      = S_SEL & ~S_WR;
    assign busy       = op_start_reg[0];
    assign bank_wr_en = wr_en & ~busy;
    assign done_valid = op_done & busy;

    genvar gi;
    generate
        for (gi = 0; gi < REG_COUNT; gi++) begin : g_bank
            assign r_load[gi] = bank_wr_en && (S_ADDR == ADDR_R_BASE + 16'(gi));
            assign i_load[gi] = bank_wr_en && (S_ADDR == ADDR_I_BASE + 16'(gi));

            reg_bank_wr_register64_r_en u_r (
                .clk     (clk),
                .reset_n (reset_n),
                .en      (r_load[gi]),
                .d       (S_DIN),
                .q       (r_q[gi])
            );

            reg_bank_wr_register64_r_en u_i (
                .clk     (clk),
                .reset_n (reset_n),
                .en      (i_load[gi]),
                .d       (S_DIN),
                .q       (i_q[gi])
            );
        end
    endgenerate

    // A bus write to OP_START overrides the completion clear; on INTERRUPT the
    // completion set is OR-ed into bit 0 so software cannot lose an event.
    always_comb begin
        op_start_next  = op_start_reg;
        int_mask_next  = int_mask_reg;
        interrupt_next = interrupt_reg;

        if (done_valid) begin
            op_start_next[0]  = 1'b0;
            interrupt_next[0] = 1'b1;
        end

        if (wr_en) begin
            if (S_ADDR == ADDR_OP_START) begin
                op_start_next = S_DIN;
            end
            if (S_ADDR == ADDR_INT_MASK) begin
                int_mask_next = S_DIN;
            end
            if (S_ADDR == ADDR_INTERRUPT) begin
                interrupt_next = {S_DIN[DATA_W-1:1], S_DIN[0] | done_valid};
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_start_reg  <= '0;
            int_mask_reg  <= '0;
            interrupt_reg <= '0;
            rd_sel_reg    <= '0;
            rd_valid_reg  <= 1'b0;
            rd_err_reg    <= 1'b0;
        end else begin
            op_start_reg  <= op_start_next;
            int_mask_reg  <= int_mask_next;
            interrupt_reg <= interrupt_next;
            rd_valid_reg  <= rd_en;
            rd_err_reg    <= rd_en & ~addr_mapped(S_ADDR);
            if (rd_en) begin
                rd_sel_reg <= S_ADDR;
            end
        end
    end

    assign R0 = r_q[0];
    assign R1 = r_q[1];
    assign R2 = r_q[2];
    assign R3 = r_q[3];
    assign R4 = r_q[4];
    assign R5 = r_q[5];
    assign R6 = r_q[6];
    assign R7 = r_q[7];
    assign R8 = r_q[8];
    assign R9 = r_q[9];
    assign I0 = i_q[0];
    assign I1 = i_q[1];
    assign I2 = i_q[2];
    assign I3 = i_q[3];
    assign I4 = i_q[4];
    assign I5 = i_q[5];
    assign I6 = i_q[6];
    assign I7 = i_q[7];
    assign I8 = i_q[8];
    assign I9 = i_q[9];

    assign OP_START  = op_start_reg;
    assign INT_MASK  = int_mask_reg;
    assign INTERRUPT = interrupt_reg;
    assign rd_sel    = rd_sel_reg;
    assign rd_valid  = rd_valid_reg;
    assign rd_err    = rd_err_reg;
    assign o_irq     = interrupt_reg[0] & int_mask_reg[0];

endmodule

// File: tb/tb_reg_bank_wr.sv
// Bench for reg_bank_wr: directed vector table, reset corner cases, then random
// traffic checked every cycle against an address-map level reference model.
module tb_reg_bank_wr;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        S_SEL;
    logic        S_WR;
    logic [15:0] S_ADDR;
    logic [63:0] S_DIN;
    logic        op_done;
    logic [63:0] R0, R1, R2, R3, R4, R5, R6, R7, R8, R9;
    logic [63:0] I0, I1, I2, I3, I4, I5, I6, I7, I8, I9;
    logic [63:0] OP_START, INT_MASK, INTERRUPT;
    logic [15:0] rd_sel;
    logic        rd_valid;
    logic        rd_err;
    logic        o_irq;

    int n_tests = 0;
    int n_fail  = 0;
    int n_txn   = 0;

    always #5 clk = ~clk;

    reg_bank_wr dut (
        .clk(clk), .reset_n(reset_n), .S_SEL(S_SEL), .S_WR(S_WR),
        .S_ADDR(S_ADDR), .S_DIN(S_DIN), .op_done(op_done),
        .R0(R0), .R1(R1), .R2(R2), .R3(R3), .R4(R4),
        .R5(R5), .R6(R6), .R7(R7), .R8(R8), .R9(R9),
        .I0(I0), .I1(I1), .I2(I2), .I3(I3), .I4(I4),
        .I5(I5), .I6(I6), .I7(I7), .I8(I8), .I9(I9),
        .OP_START(OP_START), .INT_MASK(INT_MASK), .INTERRUPT(INTERRUPT),
        .rd_sel(rd_sel), .rd_valid(rd_valid), .rd_err(rd_err), .o_irq(o_irq)
    );

    // Index order: R0..R9 = 0..9, I0..I9 = 10..19, OP_START/INT_MASK/INTERRUPT = 20..22
    logic [63:0] dut_regs [23];
    assign dut_regs[0]  = R0;  assign dut_regs[1]  = R1;  assign dut_regs[2]  = R2;
    assign dut_regs[3]  = R3;  assign dut_regs[4]  = R4;  assign dut_regs[5]  = R5;
    assign dut_regs[6]  = R6;  assign dut_regs[7]  = R7;  assign dut_regs[8]  = R8;
    assign dut_regs[9]  = R9;  assign dut_regs[10] = I0;  assign dut_regs[11] = I1;
    assign dut_regs[12] = I2;  assign dut_regs[13] = I3;  assign dut_regs[14] = I4;
    assign dut_regs[15] = I5;  assign dut_regs[16] = I6;  assign dut_regs[17] = I7;
    assign dut_regs[18] = I8;  assign dut_regs[19] = I9;  assign dut_regs[20] = OP_START;
    assign dut_regs[21] = INT_MASK;  assign dut_regs[22] = INTERRUPT;

    // Reference model state
    logic [63:0] m_regs [23];
    logic [15:0] m_sel;
    logic        m_rv;
    logic        m_re;

    function automatic int map_idx(input logic [15:0] addr);
        if (addr >= 16'h0100 && addr <= 16'h0109) return int'(addr - 16'h0100);
        if (addr >= 16'h0110 && addr <= 16'h0119) return 10 + int'(addr - 16'h0110);
        if (addr >= 16'h0120 && addr <= 16'h0122) return 20 + int'(addr - 16'h0120);
        return -1;
    endfunction

    function automatic logic [15:0] idx_addr(input int k);
        if (k < 10) return 16'h0100 + 16'(k);
        if (k < 20) return 16'h0110 + 16'(k - 10);
        return 16'h0120 + 16'(k - 20);
    endfunction

    function automatic string reg_name(input int k);
        if (k < 10) return $sformatf("R%0d", k);
        if (k < 20) return $sformatf("I%0d", k - 10);
        if (k == 20) return "OP_START";
        if (k == 21) return "INT_MASK";
        return "INTERRUPT";
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 23; k++) m_regs[k] = '0;
        m_sel = '0;
        m_rv  = 1'b0;
        m_re  = 1'b0;
    endtask

    // One clock edge of the register bank, expressed as address-map rules.
    task automatic model_step(input logic sel, input logic wr, input logic [15:0] addr,
                              input logic [63:0] din, input logic opd);
        logic [63:0] nxt [23];
        logic        busy;
        logic        done;
        int          k;
        nxt  = m_regs;
        busy = m_regs[20][0];
        done = opd && busy;
        k    = map_idx(addr);
        if (done) begin
            nxt[20][0] = 1'b0;
            nxt[22][0] = 1'b1;
        end
        if (sel && wr && k >= 0 && (k >= 20 || !busy)) begin
            nxt[k] = din;
            if (k == 22 && done) nxt[22][0] = 1'b1;
        end
        m_regs = nxt;
        m_rv   = sel && !wr;
        m_re   = m_rv && (k < 0);
        if (m_rv) m_sel = addr;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < 23; k++)
            check($sformatf("%s %s", tag, reg_name(k)), dut_regs[k], m_regs[k]);
        check({tag, " rd_sel"}, 64'(rd_sel), 64'(m_sel));
        check({tag, " rd_valid"}, 64'(rd_valid), 64'(m_rv));
        check({tag, " rd_err"}, 64'(rd_err), 64'(m_re));
        check({tag, " o_irq"}, 64'(o_irq), 64'(m_regs[22][0] & m_regs[21][0]));
    endtask

    task automatic cycle(input logic sel, input logic wr, input logic [15:0] addr,
                         input logic [63:0] din, input logic opd);
        S_SEL   = sel;
        S_WR    = wr;
        S_ADDR  = addr;
        S_DIN   = din;
        op_done = opd;
        @(posedge clk);
        model_step(sel, wr, addr, din, opd);
        #1;
        n_txn++;
        $display("[TB] txn %0d sel=%0b wr=%0b addr=%h din=%h op_done=%0b", n_txn, sel, wr, addr, din, opd);
        check_all($sformatf("txn%0d", n_txn));
        S_SEL   = 1'b0;
        S_WR    = 1'b0;
        op_done = 1'b0;
    endtask

    typedef struct {
        logic        sel;
        logic        wr;
        logic [15:0] addr;
        logic [63:0] din;
        logic        opd;
        int          chk;
        logic [63:0] exp;
        logic        exp_rv;
        logic        exp_re;
        logic        exp_irq;
        logic [15:0] exp_sel;
    } vec_t;

    vec_t vecs [23];

    initial begin
        vecs[0]  = '{1'b1, 1'b1, 16'h0103, 64'h1234, 1'b0,  3, 64'h1234, 1'b0, 1'b0, 1'b0, 16'h0000};
        vecs[1]  = '{1'b1, 1'b1, 16'h0120, 64'h1,    1'b0, 20, 64'h1,    1'b0, 1'b0, 1'b0, 16'h0000};
        vecs[2]  = '{1'b1, 1'b1, 16'h0100, 64'hFF,   1'b0,  0, 64'h0,    1'b0, 1'b0, 1'b0, 16'h0000};
        vecs[3]  = '{1'b1, 1'b1, 16'h0121, 64'h1,    1'b0, 21, 64'h1,    1'b0, 1'b0, 1'b0, 16'h0000};
        vecs[4]  = '{1'b0, 1'b0, 16'h0000, 64'h0,    1'b1, 22, 64'h1,    1'b0, 1'b0, 1'b1, 16'h0000};
        vecs[5]  = '{1'b0, 1'b0, 16'h0000, 64'h0,    1'b0, 20, 64'h0,    1'b0, 1'b0, 1'b1, 16'h0000};
        vecs[6]  = '{1'b1, 1'b1, 16'h0122, 64'h0,    1'b0, 22, 64'h0,    1'b0, 1'b0, 1'b0, 16'h0000};
        vecs[7]  = '{1'b1, 1'b1, 16'h0120, 64'h1,    1'b0, 20, 64'h1,    1'b0, 1'b0, 1'b0, 16'h0000};
        vecs[8]  = '{1'b1, 1'b1, 16'h0122, 64'h6,    1'b1, 22, 64'h7,    1'b0, 1'b0, 1'b1, 16'h0000};
        vecs[9]  = '{1'b0, 1'b0, 16'h0000, 64'h0,    1'b0, 20, 64'h0,    1'b0, 1'b0, 1'b1, 16'h0000};
        vecs[10] = '{1'b1, 1'b1, 16'h0122, 64'h0,    1'b0, 22, 64'h0,    1'b0, 1'b0, 1'b0, 16'h0000};
        vecs[11] = '{1'b0, 1'b0, 16'h0000, 64'h0,    1'b1, 22, 64'h0,    1'b0, 1'b0, 1'b0, 16'h0000};
        vecs[12] = '{1'b1, 1'b0, 16'h0121, 64'h0,    1'b0, 21, 64'h1,    1'b1, 1'b0, 1'b0, 16'h0121};
        vecs[13] = '{1'b1, 1'b0, 16'h0130, 64'h0,    1'b0, 21, 64'h1,    1'b1, 1'b1, 1'b0, 16'h0130};
        vecs[14] = '{1'b0, 1'b0, 16'h0000, 64'h0,    1'b0,  3, 64'h1234, 1'b0, 1'b0, 1'b0, 16'h0130};
        vecs[15] = '{1'b1, 1'b1, 16'h0109, 64'hAAAA, 1'b0,  9, 64'hAAAA, 1'b0, 1'b0, 1'b0, 16'h0130};
        vecs[16] = '{1'b1, 1'b1, 16'h0110, 64'h5,    1'b0, 10, 64'h5,    1'b0, 1'b0, 1'b0, 16'h0130};
        vecs[17] = '{1'b1, 1'b1, 16'h0119, 64'h9,    1'b0, 19, 64'h9,    1'b0, 1'b0, 1'b0, 16'h0130};
        vecs[18] = '{1'b1, 1'b1, 16'h010A, 64'hDEAD, 1'b0,  9, 64'hAAAA, 1'b0, 1'b0, 1'b0, 16'h0130};
        vecs[19] = '{1'b1, 1'b1, 16'h0120, 64'hF01,  1'b0, 20, 64'hF01,  1'b0, 1'b0, 1'b0, 16'h0130};
        vecs[20] = '{1'b1, 1'b1, 16'h0113, 64'h1,    1'b0, 13, 64'h0,    1'b0, 1'b0, 1'b0, 16'h0130};
        vecs[21] = '{1'b0, 1'b0, 16'h0000, 64'h0,    1'b1, 20, 64'hF00,  1'b0, 1'b0, 1'b1, 16'h0130};
        vecs[22] = '{1'b0, 1'b1, 16'h0100, 64'hBEEF, 1'b0,  0, 64'h0,    1'b0, 1'b0, 1'b1, 16'h0130};

        reset_n = 1'b0;
        S_SEL   = 1'b0;
        S_WR    = 1'b0;
        S_ADDR  = '0;
        S_DIN   = '0;
        op_done = 1'b0;
        model_reset();
        #3;
        check_all("reset");
        #4 reset_n = 1'b1;

        // Directed vectors with hand-derived expectations
        for (int v = 0; v < 23; v++) begin
            cycle(vecs[v].sel, vecs[v].wr, vecs[v].addr, vecs[v].din, vecs[v].opd);
            check($sformatf("vec%0d %s", v, reg_name(vecs[v].chk)), dut_regs[vecs[v].chk], vecs[v].exp);
            check($sformatf("vec%0d rd_valid", v), 64'(rd_valid), 64'(vecs[v].exp_rv));
            check($sformatf("vec%0d rd_err", v), 64'(rd_err), 64'(vecs[v].exp_re));
            check($sformatf("vec%0d o_irq", v), 64'(o_irq), 64'(vecs[v].exp_irq));
            check($sformatf("vec%0d rd_sel", v), 64'(rd_sel), 64'(vecs[v].exp_sel));
        end

        // Asynchronous reset in the middle of an operation, then a stale op_done
        cycle(1'b1, 1'b1, 16'h0122, 64'h0, 1'b0);
        cycle(1'b1, 1'b1, 16'h0105, 64'h55, 1'b0);
        cycle(1'b1, 1'b1, 16'h0120, 64'h3, 1'b0);
        cycle(1'b1, 1'b0, 16'h0105, 64'h0, 1'b0);
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        check_all("async_reset");
        check("async_reset OP_START", OP_START, 64'h0);
        check("async_reset o_irq", 64'(o_irq), 64'h0);
        #2 reset_n = 1'b1;
        cycle(1'b0, 1'b0, 16'h0000, 64'h0, 1'b1);
        check("stale op_done INTERRUPT", INTERRUPT, 64'h0);

        // Randomized traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            logic [15:0] a;
            int          k;
            k = int'($urandom_range(0, 25));
            if (k < 23) a = idx_addr(k);
            else        a = 16'($urandom_range(0, 16'hFFFF));
            cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), a,
                  {$urandom, $urandom}, $urandom_range(0, 3) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
